// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit in front of an internal word-wide data
// memory and an external IO bus with an ack/timeout handshake.
module mem_access_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DMEM_AW    = 12,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              io_req,
    output logic              io_wen,
    output logic [15:0]       io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ack
);

    typedef enum logic [1:0] {IDLE, DMEM_RD, IO_WAIT} state_t;

    state_t              r_state, w_state_nxt;

    logic [DATA_W-1:0]   r_mem [0:(1<<DMEM_AW)-1];
    logic [DATA_W-1:0]   r_rdword;

    logic                r_wen;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [15:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [3:0]          r_cnt, w_cnt_nxt;

    logic                r_resp_valid, w_resp_valid_nxt;
    logic                r_resp_err, w_resp_err_nxt;
    logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nxt;

    logic                w_accept;
    logic                w_is_io;
    logic                w_misalign;
    logic                w_dmem_we;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic [DMEM_AW-1:0]  w_idx;

    // Shift the addressed lane down to bit 0, then zero/sign-extend it.
    function automatic logic [DATA_W-1:0] f_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [DATA_W-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    f_extract = {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]};
            2'd1:    f_extract = {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]};
            default: f_extract = word;
        endcase
    endfunction

    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_is_io    = (req_addr[31:16] == IO_BASE[31:16]);
    assign w_misalign = (req_size == 2'd3)
                      | ((req_size == 2'd1) & req_addr[0])
                      | ((req_size == 2'd2) & (|req_addr[1:0]));
    // Addresses beyond the DMEM range alias onto it through the low index bits.
    assign w_idx      = req_addr[DMEM_AW+1:2];
    assign w_dmem_we  = w_accept & ~w_misalign & ~w_is_io & req_wen;

    // Byte enables and lane-replicated store data for the DMEM write port.
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Data memory: byte-lane writes and a synchronous read, both on acceptance.
    always_ff @(posedge clk) begin
        if (w_dmem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
        if (w_accept) begin
            r_rdword <= r_mem[w_idx];
        end
    end

    // Next-state and next-response logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_misalign) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else if (w_is_io) begin
                        w_state_nxt = IO_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (req_wen) begin
                        w_resp_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DMEM_RD;
                    end
                end
            end
            DMEM_RD: begin
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = f_extract(r_rdword, r_addr[1:0], r_size, r_signed);
                w_state_nxt      = IDLE;
            end
            IO_WAIT: begin
                // An ack on the final timeout cycle takes priority over the timeout.
                if (io_ack) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_wen ? '0
                                     : f_extract(io_rdata, r_addr[1:0], r_size, r_signed);
                    w_state_nxt      = IDLE;
                end else if (r_cnt == 4'(IO_TIMEOUT - 1)) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_state_nxt      = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, timeout counter, response and captured request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_wen        <= 1'b0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            if (w_accept) begin
                r_wen    <= req_wen;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr[15:0];
                r_wdata  <= req_wdata;
            end
        end
    end

    // IO strobes follow the state directly so a reset drops them immediately.
    assign req_ready  = (r_state == IDLE);
    assign io_req     = (r_state == IO_WAIT);
    assign io_wen     = io_req & r_wen;
    assign io_addr    = r_addr;
    assign io_wdata   = r_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
